fetch_dec_queue: RTL and testbench
==================================

FETCH_DEC_QUEUE -- requirements
Module: fetch_dec_queue

Interface
REQ-001 Parameter PC_W, default 32: program-counter width in bits.
REQ-002 Parameter INSTR_W, default 32: instruction width in bits.
REQ-003 Parameter DEPTH, default 2: entry count; power of two, 2..8.
REQ-004 Parameter NOP_INSTR, default 0: instruction value driven when the queue is empty.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 i_valid  input  1  fetch presents an entry this cycle.
REQ-008 o_ready  output  1  queue can accept an entry this cycle.
REQ-009 i_pc  input  PC_W  PC of the presented entry.
REQ-010 i_instruction  input  INSTR_W  instruction of the presented entry.
REQ-011 i_flush  input  1  discard all held entries (branch/redirect).
REQ-012 o_valid  output  1  head entry valid toward decode.
REQ-013 i_ready  input  1  decode accepts the head entry this cycle.
REQ-014 o_pc  output  PC_W  head-entry PC.
REQ-015 o_instruction  output  INSTR_W  head-entry instruction.
REQ-016 o_count  output  $clog2(DEPTH+1)  number of held entries.

Function
REQ-017 Push occurs when i_valid && o_ready && !i_flush; the entry is written at the tail.
REQ-018 Pop occurs when o_valid && i_ready && !i_flush; the head advances.
REQ-019 o_ready = (o_count < DEPTH); it does not depend on i_ready (no combinational ready path).
REQ-020 o_valid = (o_count != 0); the head is first-word-fall-through, visible in the cycle after the push edge (one-cycle latency).
REQ-021 When empty: o_pc = 0 and o_instruction = NOP_INSTR.
REQ-022 A simultaneous push and pop with 0 < count < DEPTH leaves o_count unchanged and preserves order.
REQ-023 When full, a push is refused even if a pop occurs in the same cycle; o_count decrements by one.
REQ-024 When empty, a push makes count 1 at the next edge; there is no same-cycle bypass.
REQ-025 i_flush has highest priority: at the next edge count = 0 and both pointers = 0, and any push or pop that cycle is ignored.
REQ-026 Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH; o_count saturates neither below 0 nor above DEPTH by construction.
REQ-027 Stored payload is not cleared on pop or flush; only the pointers and count change.
REQ-028 Outputs are a pure function of registered state: o_valid, o_ready, o_count, o_pc and o_instruction.

Reset
REQ-029 While rst = 0: count = 0, pointers = 0, o_valid = 0, o_ready = 1, o_count = 0, o_pc = 0, o_instruction = NOP_INSTR, asynchronously.
REQ-030 Reset asserted mid-operation discards all entries immediately.
REQ-031 The first push is accepted on the first rising edge after rst rises.
REQ-032 Payload storage is not reset.

Structure
REQ-033 NOP_INSTR value and the default PC_W/INSTR_W live in the shared CPU package/header, which the decode stage also uses.
REQ-034 Storage is a sub-module fdq_mem: DEPTH x (PC_W+INSTR_W), one synchronous write port and one asynchronous read port.
REQ-035 Pointer, count, and handshake logic stay in fetch_dec_queue.

Verification (DEPTH=2 unless stated)
REQ-036 Reset, then push (pc=5, instr=10) with i_ready=0 -> next cycle o_valid=1, o_pc=5, o_instruction=10, o_count=1.
REQ-037 Push (20,30) then (40,50) with i_ready=0 -> o_ready=0, o_count=2. Then drive i_valid with (60,70) -> refused. Then i_ready=1 for two cycles -> outputs (20,30) then (40,50), then o_valid=0 with o_instruction=NOP_INSTR.
REQ-038 count=1, push (55,67) and pop the same cycle -> o_count stays 1, head becomes (55,67).
REQ-039 count=2, assert i_flush with i_valid=1 and i_ready=1 -> next cycle o_count=0, o_valid=0, and the pushed entry is absent.
REQ-040 Assert rst=0 asynchronously mid-clock with count=2 -> outputs reach reset values before the next edge. Release rst, push (99,199) -> head (99,199).
REQ-041 DEPTH=4: 10 continuous pushes with i_ready=1 (pc=0..9) -> output PC sequence 0..9 in order through pointer wrap, o_count never exceeding 4.

Source files
------------

// File: rtl/fetch_dec_queue_pkg.sv
// Shared CPU definitions used by fetch and decode: default datapath widths
// and the instruction that decode sees when the fetch queue is empty.
package fetch_dec_queue_pkg;

    localparam int CPU_PC_W    = 32;
    localparam int CPU_INSTR_W = 32;

    localparam logic [CPU_INSTR_W-1:0] CPU_NOP_INSTR = '0;

endpackage

// File: rtl/fdq_mem.sv
// Fetch/decode queue payload storage: one synchronous write port and one
// asynchronous read port. Contents are never reset or cleared.
module fdq_mem #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_dec_queue.sv
// Fetch-to-decode skid queue: first-word-fall-through FIFO of {pc, instruction}
// with flush. All outputs are derived from registered pointers and count only.
module fetch_dec_queue
    import fetch_dec_queue_pkg::*;
#(
    parameter int                   PC_W      = CPU_PC_W,
    parameter int                   INSTR_W   = CPU_INSTR_W,
    parameter int                   DEPTH     = 2,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(CPU_NOP_INSTR),
    localparam int                  AW        = $clog2(DEPTH),
    localparam int                  CW        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0] i_instruction,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instruction,
    output logic [CW-1:0]      o_count
);

    localparam int EW = PC_W + INSTR_W;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [EW-1:0] rd_entry;

    // Ready is taken from the count alone, so a full queue refuses a push
    // even when decode drains the head in the same cycle.
    assign o_ready = (count_q < CW'(DEPTH));
    assign o_valid = (count_q != '0);
    assign o_count = count_q;

    assign push = i_valid && o_ready && !i_flush;
    assign pop  = o_valid && i_ready && !i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fdq_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({i_pc, i_instruction}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Stale payload stays in storage; mask it whenever the queue is empty.
    assign o_pc          = o_valid ? rd_entry[EW-1:INSTR_W] : '0;
    assign o_instruction = o_valid ? rd_entry[INSTR_W-1:0]  : NOP_INSTR;

endmodule

// File: tb/tb_fetch_dec_queue.sv
// Scoreboard bench for fetch_dec_queue: a DEPTH=2 instance for directed
// cases and a DEPTH=4 instance for wrap and random traffic.
module tb_fetch_dec_queue;

    localparam logic [31:0] NOP2 = 32'h0000_0013;

    logic        clk, rst;
    logic        iv [2], ir [2], fl [2], ordy [2], ov [2];
    logic [31:0] ipc [2], iins [2], opc [2], oins [2];
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;

    int          n_chk, n_fail;
    logic [63:0] expq [$];

    fetch_dec_queue #(.PC_W(32), .INSTR_W(32), .DEPTH(2), .NOP_INSTR(NOP2)) u_dut2 (
        .clk(clk), .rst(rst), .i_valid(iv[0]), .o_ready(ordy[0]), .i_pc(ipc[0]),
        .i_instruction(iins[0]), .i_flush(fl[0]), .o_valid(ov[0]), .i_ready(ir[0]),
        .o_pc(opc[0]), .o_instruction(oins[0]), .o_count(cnt2)
    );

    fetch_dec_queue #(.PC_W(32), .INSTR_W(32), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_valid(iv[1]), .o_ready(ordy[1]), .i_pc(ipc[1]),
        .i_instruction(iins[1]), .i_flush(fl[1]), .o_valid(ov[1]), .i_ready(ir[1]),
        .o_pc(opc[1]), .o_instruction(oins[1]), .o_count(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output of instance d against the scoreboard's view.
    task automatic check_outs(input int d);
        int          depth;
        logic [63:0] cnt;
        depth = (d == 1) ? 4 : 2;
        cnt   = (d == 1) ? 64'(cnt4) : 64'(cnt2);
        chk("o_count", cnt, 64'(expq.size()));
        chk("o_ready", 64'(ordy[d]), 64'(expq.size() < depth));
        chk("o_valid", 64'(ov[d]), 64'(expq.size() != 0));
        if (expq.size() != 0) begin
            chk("head_pc", 64'(opc[d]), 64'(expq[0][63:32]));
            chk("head_instr", 64'(oins[d]), 64'(expq[0][31:0]));
        end else begin
            chk("empty_pc", 64'(opc[d]), 64'd0);
            chk("empty_instr", 64'(oins[d]), (d == 1) ? 64'd0 : 64'(NOP2));
        end
    endtask

    // One clock of stimulus: drive after a falling edge, check, update the
    // scoreboard with what the rising edge will do, then move to the next falling edge.
    task automatic cyc(input int d, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic r, input logic f);
        int depth;
        bit do_push, do_pop;
        depth = (d == 1) ? 4 : 2;
        iv[d] = v; ipc[d] = pc; iins[d] = ins; ir[d] = r; fl[d] = f;
        #1;
        check_outs(d);
        do_pop  = (expq.size() != 0) && r && !f;
        do_push = v && (expq.size() < depth) && !f;
        if (f) expq.delete();
        if (do_pop) void'(expq.pop_front());
        if (do_push) expq.push_back({pc, ins});
        @(negedge clk);
        iv[d] = 1'b0; ir[d] = 1'b0; fl[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ir[k] = 1'b0; fl[k] = 1'b0; ipc[k] = '0; iins[k] = '0;
        end
        rst = 1'b0;
        #2;
        check_outs(0);
        check_outs(1);
        @(negedge clk);
        rst = 1'b1;

        // Single push, decode stalled: head visible next cycle.
        cyc(0, 1, 5, 10, 0, 0);
        chk("r036_pc", 64'(opc[0]), 64'd5);
        chk("r036_instr", 64'(oins[0]), 64'd10);
        chk("r036_count", 64'(cnt2), 64'd1);
        cyc(0, 0, 0, 0, 1, 0);

        // Fill, refused push while full, then drain in order.
        cyc(0, 1, 20, 30, 0, 0);
        cyc(0, 1, 40, 50, 0, 0);
        chk("r037_ready", 64'(ordy[0]), 64'd0);
        chk("r037_count", 64'(cnt2), 64'd2);
        cyc(0, 1, 60, 70, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("r037_valid", 64'(ov[0]), 64'd0);
        chk("r037_nop", 64'(oins[0]), 64'(NOP2));

        // Simultaneous push and pop at count 1.
        cyc(0, 1, 1, 2, 0, 0);
        cyc(0, 1, 55, 67, 1, 0);
        chk("r038_count", 64'(cnt2), 64'd1);
        chk("r038_pc", 64'(opc[0]), 64'd55);
        chk("r038_instr", 64'(oins[0]), 64'd67);

        // Full with push and pop together: push refused, count drops by one.
        cyc(0, 1, 3, 4, 0, 0);
        cyc(0, 1, 7, 8, 1, 0);
        chk("r023_count", 64'(cnt2), 64'd1);
        chk("r023_pc", 64'(opc[0]), 64'd3);

        // Flush beats push and pop.
        cyc(0, 1, 9, 9, 0, 0);
        cyc(0, 1, 77, 88, 1, 1);
        chk("r039_count", 64'(cnt2), 64'd0);
        chk("r039_valid", 64'(ov[0]), 64'd0);
        cyc(0, 1, 11, 12, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle with a full queue.
        cyc(0, 1, 13, 14, 0, 0);
        cyc(0, 1, 15, 16, 0, 0);
        #1 rst = 1'b0;
        #1 expq.delete();
        check_outs(0);
        #1 rst = 1'b1;
        @(negedge clk);
        cyc(0, 1, 99, 199, 0, 0);
        chk("r040_pc", 64'(opc[0]), 64'd99);
        chk("r040_instr", 64'(oins[0]), 64'd199);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // DEPTH=4: continuous push with decode ready, through pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 32'(i), 32'(i + 100), 1, 0);
            chk("r041_le4", 64'(cnt4 <= 3'd4), 64'd1);
        end
        // Fill past full with decode stalled, then drain.
        for (int i = 0; i < 6; i++) cyc(1, 1, 32'(200 + i), 32'(300 + i), 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 200; i++) begin
            cyc(1, 1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
